// File: rtl/i2c_csr_slave.sv
// I2C slave front-end: oversampled SCL/SDA drive single-cycle CDBUS register reads/writes.
// A START goes to address decode, a STOP returns to idle, and the register address is kept across a repeated START.
module i2c_csr_slave #(
  parameter logic [6:0] I2C_ADDR   = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       chip_select,
  output logic [4:0] csr_address,
  output logic       csr_read,
  input  logic [7:0] csr_readdata,
  output logic       csr_write,
  output logic [7:0] csr_writedata
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT_P
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [FILTER_LEN-1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic                  scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic                  scl_fp_q, scl_fp_d, sda_fp_q, sda_fp_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            rx_q, rx_d;
  logic [6:0]            tx_q, tx_d;
  logic                  rw_q, rw_d, mack_q, mack_d, load_q, load_d;
  logic                  sda_oe_q, sda_oe_d, cs_q, cs_d, read_q, read_d, write_q, write_d;
  logic [4:0]            addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  scl_rise, scl_fall, start_det, stop_det;

  // A filtered level changes only after FILTER_LEN identical synchronized samples.
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_i};
    sda_sync_d = {sda_sync_q[0], sda_i};
    scl_hist_d = {scl_hist_q[FILTER_LEN-2:0], scl_sync_q[1]};
    sda_hist_d = {sda_hist_q[FILTER_LEN-2:0], sda_sync_q[1]};
    scl_f_d    = scl_f_q;
    sda_f_d    = sda_f_q;
    if (&scl_hist_d)       scl_f_d = 1'b1;
    else if (~|scl_hist_d) scl_f_d = 1'b0;
    if (&sda_hist_d)       sda_f_d = 1'b1;
    else if (~|sda_hist_d) sda_f_d = 1'b0;
    scl_fp_d = scl_f_q;
    sda_fp_d = sda_f_q;
  end

  assign scl_rise  =  scl_f_q & ~scl_fp_q;
  assign scl_fall  = ~scl_f_q &  scl_fp_q;
  assign start_det =  sda_fp_q & ~sda_f_q & scl_f_q;
  assign stop_det  = ~sda_fp_q &  sda_f_q & scl_f_q;

  // NOTE: every signal gets a default first so no path through this block leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    mack_d    = mack_q;
    sda_oe_d  = sda_oe_q;
    cs_d      = cs_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    read_d    = 1'b0;
    write_d   = 1'b0;
    load_d    = read_q;

    // csr_readdata is valid the cycle after the read strobe; its MSB goes straight onto the pin.
    if (load_q && state_q == S_RDATA) begin
      tx_d     = csr_readdata[6:0];
      sda_oe_d = ~csr_readdata[7];
    end

    unique case (state_q)
      S_IDLE: ;
      S_ADDR, S_REG, S_WDATA: begin
        if (scl_rise) begin
          rx_d      = {rx_q[6:0], sda_f_q};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall && bit_cnt_q == 4'd8) begin
          bit_cnt_d = '0;
          sda_oe_d  = 1'b1;
          if (state_q == S_ADDR) begin
            if (rx_q[7:1] == I2C_ADDR) begin
              state_d = S_ADDR_ACK;
              cs_d    = 1'b1;
              rw_d    = rx_q[0];
            end else begin
              state_d  = S_IDLE;
              cs_d     = 1'b0;
              sda_oe_d = 1'b0;
            end
          end else if (state_q == S_REG) begin
            state_d = S_REG_ACK;
            addr_d  = rx_q[4:0];
          end else begin
            state_d = S_WDATA_ACK;
            wdata_d = rx_q;
            write_d = 1'b1;
          end
        end
      end
      S_ADDR_ACK: begin
        if (scl_fall) begin
          sda_oe_d = 1'b0;
          if (rw_q) begin
            read_d  = 1'b1;
            state_d = S_RDATA;
          end else begin
            state_d = S_REG;
          end
        end
      end
      S_REG_ACK, S_WDATA_ACK: begin
        if (scl_fall) begin
          sda_oe_d = 1'b0;
          state_d  = S_WDATA;
        end
      end
      S_RDATA: begin
        if (scl_rise) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            state_d   = S_RDATA_ACK;
          end else begin
            tx_d     = {tx_q[5:0], 1'b0};
            sda_oe_d = ~tx_q[6];
          end
        end
      end
      S_RDATA_ACK: begin
        if (scl_rise) begin
          mack_d = sda_f_q;
        end else if (scl_fall) begin
          // Only an ACK fetches another byte, so a FIFO never pops data the master refused.
          if (!mack_q) begin
            read_d  = 1'b1;
            state_d = S_RDATA;
          end else begin
            state_d = S_WAIT_P;
          end
        end
      end
      S_WAIT_P: ;
      default: state_d = S_IDLE;
    endcase

    if (stop_det) begin
      state_d   = S_IDLE;
      cs_d      = 1'b0;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
    end else if (start_det) begin
      state_d   = S_ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_fp_q   <= 1'b1;
      sda_fp_q   <= 1'b1;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      rw_q       <= 1'b0;
      mack_q     <= 1'b1;
      load_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      cs_q       <= 1'b0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_fp_q   <= scl_fp_d;
      sda_fp_q   <= sda_fp_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      rw_q       <= rw_d;
      mack_q     <= mack_d;
      load_q     <= load_d;
      sda_oe_q   <= sda_oe_d;
      cs_q       <= cs_d;
      read_q     <= read_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign sda_oe        = sda_oe_q;
  assign chip_select   = cs_q;
  assign csr_address   = addr_q;
  assign csr_read      = read_q;
  assign csr_write     = write_q;
  assign csr_writedata = wdata_q;

endmodule

// File: tb/tb_i2c_csr_slave.sv
// Bench for i2c_csr_slave: a bit-level I2C master with a transaction-level model of the
// expected register strobes, ACKs and read bytes, plus a CDBUS register-file stub.
module tb_i2c_csr_slave;

  localparam logic [6:0] SLV = 7'h50;
  localparam int         Q   = 10;  // clocks per quarter SCL period

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, chip_select, csr_read, csr_write;
  logic [4:0] csr_address;
  logic [7:0] csr_readdata, csr_writedata;

  assign sda_line = sda_m & ~sda_oe;

  i2c_csr_slave #(.I2C_ADDR(SLV), .FILTER_LEN(3)) dut (
    .clk(clk), .reset(reset), .scl_i(scl_m), .sda_i(sda_line),
    .sda_oe(sda_oe), .chip_select(chip_select), .csr_address(csr_address),
    .csr_read(csr_read), .csr_readdata(csr_readdata),
    .csr_write(csr_write), .csr_writedata(csr_writedata)
  );

  always #5 clk = ~clk;

  // Register-file stub; address 8 behaves as a pop-on-read FIFO.
  logic [7:0] stub_mem [32];
  logic [7:0] fifo_vals [4] = '{8'h3C, 8'hC3, 8'h5A, 8'hEE};
  logic [1:0] fifo_idx;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) stub_mem[i] <= 8'(i * 37 + 5);
      fifo_idx     <= '0;
      csr_readdata <= 8'h00;
    end else begin
      if (csr_write) stub_mem[csr_address] <= csr_writedata;
      if (csr_read) begin
        if (csr_address == 5'd8) begin
          csr_readdata <= fifo_vals[fifo_idx];
          fifo_idx     <= fifo_idx + 2'd1;
        end else begin
          csr_readdata <= stub_mem[csr_address];
        end
      end
    end
  end

  typedef struct packed { logic [4:0] a; logic [7:0] d; } wr_t;
  wr_t        exp_wr [$];
  logic [4:0] exp_rd [$];
  logic [7:0] model_mem [32];
  logic [4:0] m_addr;
  int         n_checks = 0, n_err = 0;
  int         n_writes = 0, n_reads = 0, busy_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare process: every strobe must match the next expected access from the model.
  logic wr_prev = 1'b0, rd_prev = 1'b0;
  wr_t  w_pop;
  logic [4:0] r_pop;
  always @(negedge clk) begin
    if (!reset) begin
      if (csr_write) begin
        n_writes++;
        check("csr_write expected", 32'(exp_wr.size() > 0), 1);
        check("csr_write width", 32'(wr_prev), 0);
        if (exp_wr.size() > 0) begin
          w_pop = exp_wr.pop_front();
          check("csr_write address", 32'(csr_address), 32'(w_pop.a));
          check("csr_writedata", 32'(csr_writedata), 32'(w_pop.d));
        end
      end
      if (csr_read) begin
        n_reads++;
        check("csr_read expected", 32'(exp_rd.size() > 0), 1);
        check("csr_read width", 32'(rd_prev), 0);
        if (exp_rd.size() > 0) begin
          r_pop = exp_rd.pop_front();
          check("csr_read address", 32'(csr_address), 32'(r_pop));
        end
      end
      if (sda_oe || chip_select) busy_cycles++;
    end
    wr_prev = csr_write;
    rd_prev = csr_read;
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_mem[i] = 8'(i * 37 + 5);
    m_addr = '0;
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic do_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0;
  endtask

  task automatic do_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  // One SCL period entered with SCL low; optional 1-clk glitches in both phases.
  task automatic bit_cycle(input logic b, input logic glitch, output logic s);
    wait_q();
    sda_m = b;
    if (glitch) begin
      repeat (Q/2) @(negedge clk); scl_m = 1'b1;
      @(negedge clk);              scl_m = 1'b0;
      repeat (Q/2 - 1) @(negedge clk);
    end else begin
      wait_q();
    end
    scl_m = 1'b1;
    if (glitch) begin
      repeat (Q/2) @(negedge clk); scl_m = 1'b0;
      @(negedge clk);              scl_m = 1'b1;
      repeat (Q/2 - 1) @(negedge clk);
    end else begin
      wait_q();
    end
    s = sda_line;
    wait_q();
    scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic glitch, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], glitch, s);
    bit_cycle(1'b1, 1'b0, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic s;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      bit_cycle(1'b1, 1'b0, s);
      b = {b[6:0], s};
    end
    bit_cycle(nack, 1'b0, s);
  endtask

  task automatic end_txn();
    do_stop();
    repeat (2*Q) @(negedge clk);
    check("chip_select after STOP", 32'(chip_select), 0);
  endtask

  task automatic wr_txn(input logic [7:0] reg_b, input int n, input logic [23:0] data,
                        input logic glitch);
    logic ack;
    logic [7:0] d;
    do_start();
    send_byte({SLV, 1'b0}, 1'b0, ack);
    check("write address ACK", 32'(ack), 0);
    check("chip_select on match", 32'(chip_select), 1);
    send_byte(reg_b, 1'b0, ack);
    check("register byte ACK", 32'(ack), 0);
    m_addr = reg_b[4:0];
    for (int k = 0; k < n; k++) begin
      d = data[23 - 8*k -: 8];
      exp_wr.push_back('{a: m_addr, d: d});
      model_mem[m_addr] = d;
      send_byte(d, glitch, ack);
      check("data byte ACK", 32'(ack), 0);
    end
    end_txn();
  endtask

  task automatic rd_txn(input logic set_ptr, input logic [7:0] reg_b, input int n,
                        input logic use_fixed, input logic [15:0] fixed);
    logic ack;
    logic [7:0] b, e;
    do_start();
    if (set_ptr) begin
      send_byte({SLV, 1'b0}, 1'b0, ack);
      check("pointer address ACK", 32'(ack), 0);
      send_byte(reg_b, 1'b0, ack);
      check("pointer register ACK", 32'(ack), 0);
      m_addr = reg_b[4:0];
      do_start();
    end
    for (int k = 0; k < n; k++) exp_rd.push_back(m_addr);
    send_byte({SLV, 1'b1}, 1'b0, ack);
    check("read address ACK", 32'(ack), 0);
    check("chip_select during read", 32'(chip_select), 1);
    for (int k = 0; k < n; k++) begin
      e = use_fixed ? ((k == 0) ? fixed[15:8] : fixed[7:0]) : model_mem[m_addr];
      recv_byte(k == n - 1, b);
      check("read data byte", 32'(b), 32'(e));
    end
    end_txn();
  endtask

  task automatic mm_txn(input logic [6:0] a, input logic rw);
    logic ack;
    int   busy0;
    busy0 = busy_cycles;
    do_start();
    send_byte({a, rw}, 1'b0, ack);
    check("mismatch address NACK", 32'(ack), 1);
    send_byte(8'h5A, 1'b0, ack);
    check("mismatch data NACK", 32'(ack), 1);
    do_stop();
    wait_q();
    check("mismatch sda_oe/chip_select cycles", 32'(busy_cycles - busy0), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         w0, r0, sel, n;
    logic [7:0] rb;
    logic [6:0] ma;
    logic [7:0] ab;
    logic       s;

    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset sda_oe", 32'(sda_oe), 0);
    check("reset chip_select", 32'(chip_select), 0);
    check("reset csr_read", 32'(csr_read), 0);
    check("reset csr_write", 32'(csr_write), 0);
    check("reset csr_address", 32'(csr_address), 0);
    check("reset csr_writedata", 32'(csr_writedata), 0);
    reset = 1'b0;
    repeat (2*Q) @(negedge clk);

    // Single write of 0xA5 to register 3.
    w0 = n_writes;
    wr_txn(8'h03, 1, 24'hA5_0000, 1'b0);
    check("single write count", 32'(n_writes - w0), 1);
    check("stub reg 3 after write", 32'(stub_mem[3]), 32'h A5);

    // Address 0x51 is not ours.
    mm_txn(7'h51, 1'b0);

    // Pointer write, repeated START, read two bytes from the FIFO at register 8.
    r0 = n_reads;
    rd_txn(1'b1, 8'h08, 2, 1'b1, 16'h3CC3);
    check("FIFO read count", 32'(n_reads - r0), 2);

    // Three streamed bytes to register 0x0A.
    w0 = n_writes;
    wr_txn(8'h0A, 3, 24'h112233, 1'b0);
    check("streamed write count", 32'(n_writes - w0), 3);
    check("stub reg 0x0A last byte", 32'(stub_mem[10]), 32'h33);

    // SCL glitches during data bytes; upper register bits ignored.
    wr_txn(8'hE4, 2, 24'h96_6900, 1'b1);
    check("stub reg 4 after glitched write", 32'(stub_mem[4]), 32'h69);

    // Reset while the slave drives the address ACK.
    do_start();
    ab = {SLV, 1'b0};
    for (int i = 7; i >= 0; i--) bit_cycle(ab[i], 1'b0, s);
    wait_q();
    check("ACK driven before reset", 32'(sda_oe), 1);
    reset = 1'b1;
    @(negedge clk);
    check("sda_oe after mid-ACK reset", 32'(sda_oe), 0);
    check("chip_select after mid-ACK reset", 32'(chip_select), 0);
    check("strobes after mid-ACK reset", 32'({csr_read, csr_write}), 0);
    reset = 1'b0;
    model_reset();
    wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0;
    do_stop();
    wait_q();
    wr_txn(8'h07, 1, 24'h5E_0000, 1'b0);
    rd_txn(1'b0, 8'h00, 1, 1'b0, 16'h0);  // bare read reuses the retained pointer

    // Randomized transactions.
    for (int it = 0; it < 14; it++) begin
      sel = $urandom_range(0, 9);
      n   = $urandom_range(1, 3);
      if (sel < 2) begin
        ma = 7'($urandom_range(0, 127));
        if (ma == SLV) ma = 7'h51;
        mm_txn(ma, 1'($urandom_range(0, 1)));
      end else if (sel < 6) begin
        rb = 8'($urandom_range(0, 255));
        wr_txn(rb, n, 24'($urandom), 1'($urandom_range(0, 1)));
      end else begin
        rb = 8'($urandom_range(0, 255));
        if (rb[4:0] == 5'd8) rb[4:0] = 5'd9;
        rd_txn((m_addr == 5'd8) || 1'($urandom_range(0, 1)), rb, n, 1'b0, 16'h0);
      end
      repeat ($urandom_range(Q, 4*Q)) @(negedge clk);
    end

    repeat (4*Q) @(negedge clk);
    check("no outstanding writes", 32'(exp_wr.size()), 0);
    check("no outstanding reads", 32'(exp_rd.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_csr_slave.md
# i2c_csr_slave

I2C slave front-end that turns I2C transactions into single-cycle accesses on the 8-bit CDBUS register bus (csr_address/read/write/readdata/writedata plus chip_select). It is the alternative host-interface stage to the SPI slave: it drives the same register-bus inputs of the cdbus core, for boards that expose only SCL/SDA. All logic runs on the system clock. SCL and SDA are oversampled, and no logic is clocked by SCL.

## Interface
- I2C_ADDR, 7'h50: 7-bit slave address this block responds to.
- FILTER_LEN, 3: number of consecutive equal samples required before a synchronized SCL/SDA level is accepted (glitch filter).

- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- scl_i  in  1  I2C clock pin input (asynchronous).
- sda_i  in  1  I2C data pin input (asynchronous).
- sda_oe  out  1  1 = pull SDA low (open-drain); the top level ties SDA to 0 when set, Z otherwise.
- chip_select  out  1  high while a transaction addressed to I2C_ADDR is in progress.
- csr_address  out  5  register address.
- csr_read  out  1  one-cycle read strobe.
- csr_readdata  in  8  read data; valid the cycle after csr_read.
- csr_write  out  1  one-cycle write strobe.
- csr_writedata  out  8  write data; valid together with csr_write.

## Operation
- Input conditioning:
  - Each pin passes through a 2-FF synchronizer, then a FILTER_LEN-sample filter, giving scl_f and sda_f.
  - Edges and conditions are detected on the filtered signals:
    - SCL rise/fall: change of scl_f.
    - START: sda_f falls while scl_f = 1.
    - STOP: sda_f rises while scl_f = 1.
- Bits are sampled on scl_f rise, MSB first.
- State machine:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - Address match: on match of bits[7:1] with I2C_ADDR, go to ADDR_ACK.
    - Mismatch: go to IDLE, with no ACK and chip_select low.
  - ADDR_ACK:
    - Drive ACK.
    - R/W=0: next state is REG.
    - R/W=1: next state is RDATA, after a fetch.
  - REG: shift 8 bits; csr_address <= bits[4:0]; bits[7:5] are ignored. Then REG_ACK → WDATA.
  - WDATA: shift 8 bits, then WDATA_ACK.
    - In WDATA_ACK, issue a csr_write pulse with that byte at the current csr_address, then return to WDATA.
    - The address does not increment, so repeated bytes stream into FIFO-style registers.
  - RDATA: shift out the fetched byte, then RDATA_ACK.
    - RDATA_ACK samples the master's ACK/NACK.
    - ACK (0): fetch the next byte and return to RDATA.
    - NACK (1): go to WAIT_P, which releases SDA and waits for STOP or START.
- Fetch:
  - A one-cycle csr_read pulse at the current csr_address; csr_readdata is latched into the TX shift register on the following cycle.
  - A fetch occurs only when ADDR_ACK (read) completes and when the master ACKs in RDATA_ACK. It never occurs after a NACK, so a FIFO never pops unread data.
- START in any state (including repeated START) → ADDR. csr_address is retained, so write-pointer then repeated-START-read works.
- STOP in any state → IDLE.
- chip_select:
  - Set on address match.
  - Cleared on STOP, on a START that is not followed by a match, and on reset.
- Reset values:
  - sda_oe=0, chip_select=0, csr_read=0, csr_write=0, csr_address=0, csr_writedata=0, state=IDLE.
  - Filters are initialised to 1 (idle bus).

## Timing
- Input latency is 2 sync + FILTER_LEN cycles.
- Requires clk ≥ 20× SCL frequency; with a 10 MHz SCL region excluded, 400 kHz needs clk ≥ 8 MHz.
- SDA changes only one clk after a scl_f fall. This applies to both ACK and read-data bits and gives hold time.
- ACK drive: sda_oe=1 from the scl_f fall that ends bit 8 to the next scl_f fall.
- csr_write: asserted for exactly one clk, in the cycle after the scl_f fall that ends the 8th data bit. csr_writedata is stable from that cycle until the next write.
- csr_read: asserted for exactly one clk, in the cycle after the scl_f fall that ends the ACK bit. The byte is loaded on the next cycle, and the MSB is driven from the cycle after that, well before the next SCL rise.
- Read bit = 1 means sda_oe=0; bit = 0 means sda_oe=1.
- Reset mid-transaction: the next cycle has sda_oe=0 and chip_select=0, and all strobes are suppressed.

## Test plan
- Write 0x50+W, reg 0x03, data 0xA5 → ACK on all three bytes; a single csr_write with csr_address=3, csr_writedata=0xA5; chip_select high until STOP.
- Address 0x51+W (mismatch) → sda_oe never asserted; no strobes; chip_select stays 0.
- 0x50+W, reg 0x08, repeated START, 0x50+R, stub returns 0x3C then 0xC3, master ACK then NACK → master reads 0x3C, 0xC3; exactly 2 csr_read pulses, both at address 8; no third read.
- Write three bytes 0x11, 0x22, 0x33 to reg 0x0A → three csr_write pulses, all at address 0x0A, data in order.
- 1-cycle glitches on SCL during a data byte (FILTER_LEN=3) → byte is received unchanged; no spurious START or STOP.
- Assert reset while the block is driving ACK → sda_oe=0 next cycle; a subsequent clean write transaction completes normally.
